// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared widths, word type and FSM states for the calc feeder
package calc_pkg;

    localparam int CALC_W     = 32;
    localparam int CALC_N     = 6;
    localparam int CALC_WORDS = 72;

    typedef logic [CALC_W-1:0] calc_word_t;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        RESP
    } calc_feed_state_t;

endpackage

// File: rtl/calc_operand_bank.sv
// rtl/calc_operand_bank.sv - N*N-entry operand register bank with flattened read bus
module calc_operand_bank #(
    parameter int W     = calc_pkg::CALC_W,
    parameter int DEPTH = calc_pkg::CALC_N * calc_pkg::CALC_N,
    parameter int IDX_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IDX_W-1:0]   widx,
    input  logic [W-1:0]       wdata,
    output logic [DEPTH*W-1:0] rd_bus
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    // Write the addressed entry; all others hold their previous value.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (we && (widx == IDX_W'(i))) begin
                mem_d[i] = wdata;
            end
        end
    end

    // Bank storage, cleared on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign rd_bus[g*W +: W] = mem_q[g];
    end

endmodule

// File: rtl/calc_feeder.sv
// rtl/calc_feeder.sv - operand loader / result sampler for calc; optional CALC_FEEDER_STATUS_EN
module calc_feeder #(
    parameter int W      = calc_pkg::CALC_W,
    parameter int N      = calc_pkg::CALC_N,
    parameter int SETTLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic               in_last,
    output logic [N*N*W-1:0]   op_a,
    output logic [N*N*W-1:0]   op_b,
    input  logic [W-1:0]       calc_f,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               out_err
`ifdef CALC_FEEDER_STATUS_EN
    ,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         err_cnt
`endif
);

    import calc_pkg::*;

    localparam int NN    = N * N;
    localparam int WORDS = 2 * NN;
    localparam int IDX_W = 7;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] NN_IDX   = IDX_W'(NN);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    calc_feed_state_t   state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic               out_err_q, out_err_d;

    logic               xfer;
    logic               a_we;
    logic               b_we;
    logic [IDX_W-1:0]   b_idx;

`ifdef CALC_FEEDER_STATUS_EN
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    assign busy      = (state_q != LOAD);
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == RESP);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    // First half of a frame goes to bank A, second half to bank B.
    assign xfer  = in_valid && in_ready;
    assign a_we  = xfer && (idx_q < NN_IDX);
    assign b_we  = xfer && (idx_q >= NN_IDX);
    assign b_idx = idx_q - NN_IDX;

    calc_operand_bank #(.W(W), .DEPTH(NN), .IDX_W(IDX_W)) u_bank_a (
        .clk    (clk),
        .rst    (rst),
        .we     (a_we),
        .widx   (idx_q),
        .wdata  (in_data),
        .rd_bus (op_a)
    );

    calc_operand_bank #(.W(W), .DEPTH(NN), .IDX_W(IDX_W)) u_bank_b (
        .clk    (clk),
        .rst    (rst),
        .we     (b_we),
        .widx   (b_idx),
        .wdata  (in_data),
        .rd_bus (op_b)
    );

    // Frame sequencing: load words, wait for calc to settle, hold the result until taken.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
`ifdef CALC_FEEDER_STATUS_EN
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        // Full frame; a missing in_last is flagged but F is still sampled.
                        state_d = calc_pkg::SETTLE;
                        cnt_d   = CNT_LOAD;
                        err_d   = !in_last;
                    end else if (in_last) begin
                        // Short frame: answer at once with an error and no sample.
                        state_d    = RESP;
                        idx_d      = idx_q + 1'b1;
                        out_data_d = '0;
                        out_err_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            calc_pkg::SETTLE: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    out_data_d = calc_f;
                    out_err_d  = err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
`ifdef CALC_FEEDER_STATUS_EN
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (out_err_q && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
`ifdef CALC_FEEDER_STATUS_EN
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
`ifdef CALC_FEEDER_STATUS_EN
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_calc_feeder.sv
// tb/tb_calc_feeder.sv - self-checking bench for calc_feeder with an integer-valued calc stand-in
module tb_calc_feeder;

    localparam int W      = 32;
    localparam int N      = 6;
    localparam int NN     = N * N;
    localparam int WORDS  = 2 * NN;
    localparam int SETTLE = 4;
    localparam logic [31:0] ONE = 32'h3F800000;
    localparam logic [31:0] TWO = 32'h40000000;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              in_last;
    logic [NN*W-1:0]   op_a;
    logic [NN*W-1:0]   op_b;
    logic [W-1:0]      calc_f;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              out_err;
`ifdef CALC_FEEDER_STATUS_EN
    logic              busy;
    logic [15:0]       frame_cnt;
    logic [7:0]        err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int ma [NN];
    int mb [NN];

    always #5 clk = ~clk;

    calc_feeder #(.W(W), .N(N), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .op_a      (op_a),
        .op_b      (op_b),
        .calc_f    (calc_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
`ifdef CALC_FEEDER_STATUS_EN
        ,
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    // Small non-negative integers encoded as IEEE-754 single.
    function automatic logic [31:0] i2f(input int v);
        int p;
        logic [31:0] sh;
        if (v <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (((v >> i) & 1) != 0) p = i;
        sh = 32'(v) << (23 - p);
        return {1'b0, 8'(p + 127), sh[22:0]};
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int e;
        logic [23:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0 || e > 23) return -1;
        m = {1'b1, f[22:0]};
        m = m >> (23 - e);
        return int'(m);
    endfunction

    // Stand-in for calc: F = sum over all 36 positions of a*b.
    function automatic logic [31:0] calc_model(input logic [NN*W-1:0] a, input logic [NN*W-1:0] b);
        int s;
        s = 0;
        for (int i = 0; i < NN; i++) s += f2i(a[i*W +: W]) * f2i(b[i*W +: W]);
        return i2f(s);
    endfunction

    assign calc_f = calc_model(op_a, op_b);

    task automatic clear_model();
        for (int i = 0; i < NN; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
    endtask

    // Offers one word; starts and ends on a falling edge.
    task automatic put_word(input logic [31:0] d, input bit last, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_load: got %b want 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends one frame, updates the model and collects the response observations.
    task automatic run_frame(input int len, input bit with_last, input bit rnd,
                             input logic [31:0] av, input logic [31:0] bv,
                             input int gap_max, input int bp,
                             output int lat, output logic [31:0] dat, output logic e,
                             output int unstable, output bit drop_ok,
                             output logic [31:0] exp_d, output logic exp_e, output int ops_bad);
        int v;
        int s;
        int gap;
        for (int i = 0; i < len; i++) begin
            if (rnd) v = int'($urandom_range(0, 3));
            else     v = (i < NN) ? f2i(av) : f2i(bv);
            if (i < NN) ma[i] = v;
            else        mb[i-NN] = v;
            gap = 0;
            if (gap_max > 0 && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, gap_max));
            put_word(i2f(v), with_last && (i == len - 1), gap);
        end
        if (len < WORDS) begin
            exp_d = 32'h0;
            exp_e = 1'b1;
        end else begin
            s = 0;
            for (int i = 0; i < NN; i++) s += ma[i] * mb[i];
            exp_d = i2f(s);
            exp_e = !with_last;
        end
        unstable = 0;
        drop_ok  = 1'b0;
        ops_bad  = 0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) begin
            lat = -1;
            dat = 32'hxxxxxxxx;
            e   = 1'bx;
            return;
        end
        dat = out_data;
        e   = out_err;
        for (int i = 0; i < NN; i++) begin
            if (op_a[i*W +: W] !== i2f(ma[i])) ops_bad++;
            if (op_b[i*W +: W] !== i2f(mb[i])) ops_bad++;
        end
        repeat (bp) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== dat || out_err !== e || in_ready !== 1'b0) unstable++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drop_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (out_err !== 1'b0)   begin errors++; $display("FAIL rst_out_err: got %b want 0", out_err); end
        checks++; if (op_a !== '0)        begin errors++; $display("FAIL rst_op_a: nonzero bus"); end
        checks++; if (op_b !== '0)        begin errors++; $display("FAIL rst_op_b: nonzero bus"); end
`ifdef CALC_FEEDER_STATUS_EN
        checks++; if (busy !== 1'b0 || frame_cnt !== 16'h0 || err_cnt !== 8'h0) begin
            errors++; $display("FAIL rst_status: busy %b frame %0d err %0d want 0 0 0", busy, frame_cnt, err_cnt);
        end
`endif
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_unit_frame();
        int lat, unst, ob; logic [31:0] d, ed; logic e, ee; bit dok;
        run_frame(WORDS, 1'b1, 1'b0, ONE, ONE, 0, 0, lat, d, e, unst, dok, ed, ee, ob);
        checks++; if (lat != SETTLE + 1)  begin errors++; $display("FAIL unit_latency: got %0d want %0d", lat, SETTLE + 1); end
        checks++; if (d !== 32'h42100000) begin errors++; $display("FAIL unit_data: got %h want 42100000", d); end
        checks++; if (e !== 1'b0)         begin errors++; $display("FAIL unit_err: got %b want 0", e); end
        checks++; if (ob != 0)            begin errors++; $display("FAIL unit_operands: %0d wrong entries want 0", ob); end
        checks++; if (!dok)               begin errors++; $display("FAIL unit_drop: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        int lat, unst, ob; logic [31:0] d, ed; logic e, ee; bit dok;
        run_frame(WORDS, 1'b1, 1'b0, ONE, TWO, 1, 10, lat, d, e, unst, dok, ed, ee, ob);
        checks++; if (d !== 32'h42900000) begin errors++; $display("FAIL bp_data: got %h want 42900000", d); end
        checks++; if (unst != 0)          begin errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", unst); end
        checks++; if (lat != SETTLE + 1)  begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, SETTLE + 1); end
        checks++; if (!dok)               begin errors++; $display("FAIL bp_drop: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_early_last();
        int lat, unst, ob; logic [31:0] d, ed; logic e, ee; bit dok;
        run_frame(10, 1'b1, 1'b0, ONE, ONE, 0, 2, lat, d, e, unst, dok, ed, ee, ob);
        checks++; if (lat != 1)           begin errors++; $display("FAIL early_latency: got %0d want 1", lat); end
        checks++; if (d !== 32'h0)        begin errors++; $display("FAIL early_data: got %h want 0", d); end
        checks++; if (e !== 1'b1)         begin errors++; $display("FAIL early_err: got %b want 1", e); end
        checks++; if (ob != 0)            begin errors++; $display("FAIL early_operands: %0d wrong entries want 0", ob); end
        run_frame(WORDS, 1'b1, 1'b0, ONE, ONE, 0, 0, lat, d, e, unst, dok, ed, ee, ob);
        checks++; if (d !== 32'h42100000 || e !== 1'b0) begin
            errors++; $display("FAIL early_recover: got %h/%b want 42100000/0", d, e);
        end
    endtask

    task automatic test_missing_last();
        int lat, unst, ob; logic [31:0] d, ed; logic e, ee; bit dok;
        run_frame(WORDS, 1'b0, 1'b0, ONE, ONE, 0, 0, lat, d, e, unst, dok, ed, ee, ob);
        checks++; if (e !== 1'b1)         begin errors++; $display("FAIL nolast_err: got %b want 1", e); end
        checks++; if (d !== 32'h42100000) begin errors++; $display("FAIL nolast_data: got %h want 42100000", d); end
        checks++; if (lat != SETTLE + 1)  begin errors++; $display("FAIL nolast_latency: got %0d want %0d", lat, SETTLE + 1); end
        run_frame(WORDS, 1'b1, 1'b0, ONE, ONE, 0, 0, lat, d, e, unst, dok, ed, ee, ob);
        checks++; if (e !== 1'b0)         begin errors++; $display("FAIL nolast_clear: got %b want 0", e); end
    endtask

    task automatic test_mid_frame_reset();
        int lat, unst, ob, spurious; logic [31:0] d, ed; logic e, ee; bit dok;
        for (int i = 0; i < 40; i++) put_word(i2f(int'($urandom_range(1, 3))), 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (op_a !== '0 || op_b !== '0) begin errors++; $display("FAIL midrst_operands: buses not cleared"); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        clear_model();
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL midrst_spurious: %0d cycles of out_valid want 0", spurious); end
        run_frame(WORDS, 1'b1, 1'b0, ONE, ONE, 0, 0, lat, d, e, unst, dok, ed, ee, ob);
        checks++; if (d !== 32'h42100000 || e !== 1'b0 || lat != SETTLE + 1) begin
            errors++; $display("FAIL midrst_frame: got %h/%b lat %0d want 42100000/0 lat %0d", d, e, lat, SETTLE + 1);
        end
    endtask

    task automatic test_random();
        int lat, unst, ob, len, kind, inj, want_lat; logic [31:0] d, ed; logic e, ee; bit dok, lst;
        pulse_reset();
        inj = 0;
        for (int f = 0; f < 200; f++) begin
            kind = int'($urandom_range(0, 9));
            len  = WORDS;
            lst  = 1'b1;
            if (kind == 7 || kind == 8) len = int'($urandom_range(1, WORDS - 1));
            if (kind == 9) lst = 1'b0;
            run_frame(len, lst, 1'b1, 32'h0, 32'h0, 2, int'($urandom_range(0, 3)),
                      lat, d, e, unst, dok, ed, ee, ob);
            if (ee) inj++;
            want_lat = (len < WORDS) ? 1 : SETTLE + 1;
            checks++; if (d !== ed)        begin errors++; $display("FAIL rnd_data f%0d: got %h want %h", f, d, ed); end
            checks++; if (e !== ee)        begin errors++; $display("FAIL rnd_err f%0d: got %b want %b", f, e, ee); end
            checks++; if (lat != want_lat) begin errors++; $display("FAIL rnd_latency f%0d: got %0d want %0d", f, lat, want_lat); end
            checks++; if (unst != 0)       begin errors++; $display("FAIL rnd_stable f%0d: %0d unstable want 0", f, unst); end
            checks++; if (ob != 0)         begin errors++; $display("FAIL rnd_operands f%0d: %0d wrong want 0", f, ob); end
            checks++; if (!dok)            begin errors++; $display("FAIL rnd_drop f%0d: out_valid %b in_ready %b want 0 1", f, out_valid, in_ready); end
        end
`ifdef CALC_FEEDER_STATUS_EN
        checks++; if (frame_cnt !== 16'd200) begin errors++; $display("FAIL status_frames: got %0d want 200", frame_cnt); end
        checks++; if (int'(err_cnt) != ((inj > 255) ? 255 : inj)) begin
            errors++; $display("FAIL status_errs: got %0d want %0d", err_cnt, inj);
        end
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_unit_frame();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_mid_frame_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
